// File: rtl/semaphore_monitor.sv
// rtl/semaphore_monitor.sv - lamp-pin decoder, phase tracker and sequence/dwell watchdog
// Dwell timing checks are compiled in only when SEMAPHORE_MON_TIMING_EN is defined.
module semaphore_monitor #(
  parameter int RED_CYCLES    = 51,
  parameter int RY_CYCLES     = 11,
  parameter int GREEN_CYCLES  = 31,
  parameter int YELLOW_CYCLES = 11,
  parameter int DW            = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          red,
  input  logic          yellow,
  input  logic          green,
  input  logic          fault_clr,
  output logic [3:0]    phase,
  output logic [DW-1:0] dwell,
  output logic          err_seq,
  output logic          err_time,
  output logic          fault,
  output logic [7:0]    loops
);

  typedef enum logic [3:0] {
    PH_OFF    = 4'b0001,
    PH_RED    = 4'b0010,
    PH_RY     = 4'b0011,
    PH_GREEN  = 4'b0100,
    PH_YELLOW = 4'b0101,
    PH_BAD    = 4'b1111
  } phase_e;

  localparam logic [DW-1:0] DWELL_ONE = DW'(1);

  logic [2:0]    lamp_q, lamp_d;
  phase_e        phase_q, phase_d, dec;
  logic [DW-1:0] dwell_q, dwell_d, req_dwell;
  logic          err_seq_q, err_seq_d;
  logic          err_time_q, err_time_d;
  logic          fault_q, fault_d;
  logic [7:0]    loops_q, loops_d;
  logic          legal, timed, timing_en;

`ifdef SEMAPHORE_MON_TIMING_EN
  assign timing_en = 1'b1;
`else
  assign timing_en = 1'b0;
`endif

  assign lamp_d = {red, yellow, green};

  always_comb begin
    case (lamp_q)
      3'b000:  dec = PH_OFF;
      3'b100:  dec = PH_RED;
      3'b110:  dec = PH_RY;
      3'b001:  dec = PH_GREEN;
      3'b010:  dec = PH_YELLOW;
      default: dec = PH_BAD;
    endcase
  end

  // Only the four lit phases have a required dwell; OFF and BAD are never timed.
  always_comb begin
    timed = 1'b1;
    case (phase_q)
      PH_RED:    req_dwell = DW'(RED_CYCLES);
      PH_RY:     req_dwell = DW'(RY_CYCLES);
      PH_GREEN:  req_dwell = DW'(GREEN_CYCLES);
      PH_YELLOW: req_dwell = DW'(YELLOW_CYCLES);
      default: begin
        req_dwell = '0;
        timed     = 1'b0;
      end
    endcase
  end

  always_comb begin
    legal = (dec == PH_OFF);
    case (phase_q)
      PH_OFF:    if (dec == PH_RED)    legal = 1'b1;
      PH_RED:    if (dec == PH_RY)     legal = 1'b1;
      PH_RY:     if (dec == PH_GREEN)  legal = 1'b1;
      PH_GREEN:  if (dec == PH_YELLOW) legal = 1'b1;
      PH_YELLOW: if (dec == PH_RED)    legal = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    phase_d    = phase_q;
    dwell_d    = dwell_q;
    err_seq_d  = 1'b0;
    err_time_d = 1'b0;
    loops_d    = loops_q;
    if (dec == phase_q) begin
      if (dwell_q != '1) dwell_d = dwell_q + DWELL_ONE;
    end else begin
      phase_d    = dec;
      dwell_d    = DWELL_ONE;
      err_seq_d  = !legal;
      err_time_d = timing_en && legal && timed && (dec != PH_OFF) && (dwell_q != req_dwell);
      if (phase_q == PH_YELLOW && dec == PH_RED) loops_d = loops_q + 8'd1;
    end
    // A new error outranks a clear request in the same cycle.
    if (err_seq_d || err_time_d) fault_d = 1'b1;
    else if (fault_clr)          fault_d = 1'b0;
    else                         fault_d = fault_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_q     <= 3'b000;
      phase_q    <= PH_OFF;
      dwell_q    <= '0;
      err_seq_q  <= 1'b0;
      err_time_q <= 1'b0;
      fault_q    <= 1'b0;
      loops_q    <= 8'd0;
    end else begin
      lamp_q     <= lamp_d;
      phase_q    <= phase_d;
      dwell_q    <= dwell_d;
      err_seq_q  <= err_seq_d;
      err_time_q <= err_time_d;
      fault_q    <= fault_d;
      loops_q    <= loops_d;
    end
  end

  assign phase    = phase_q;
  assign dwell    = dwell_q;
  assign err_seq  = err_seq_q;
  assign err_time = err_time_q;
  assign fault    = fault_q;
  assign loops    = loops_q;

endmodule

// File: doc/semaphore_monitor.md
# semaphore_monitor

Passive checker that sits on the lamp outputs of the traffic-light controller and decodes the red/yellow/green pins back into a phase code. It tracks the phase, measures how long each phase lasts, and flags illegal lamp patterns, illegal phase transitions and wrong phase durations. It is the receiving end of the lamp interface and is used in-system as a safety watchdog and on the bench as a scoreboard.

## Interface
- `RED_CYCLES`, default 51: required RED dwell, in clock cycles.
- `RY_CYCLES`, default 11: required RED+YELLOW dwell.
- `GREEN_CYCLES`, default 31: required GREEN dwell.
- `YELLOW_CYCLES`, default 11: required YELLOW dwell.
- `DW`, default 7: dwell counter width. Must hold the largest `*_CYCLES` value.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `red`, `yellow`, `green`  in  1 each  observed lamp pins.
- `fault_clr`  in  1  clears the sticky `fault` flag.
- `phase`  out  4  decoded phase. Codes: OFF=0001, RED=0010, RED_YELLOW=0011, GREEN=0100, YELLOW=0101, BAD=1111.
- `dwell`  out  DW  cycles spent in the current phase, counting the current cycle. Saturates at all-ones.
- `err_seq`  out  1  one-cycle pulse on an illegal pattern or an illegal transition.
- `err_time`  out  1  one-cycle pulse on a wrong dwell.
- `fault`  out  1  sticky; set by either error pulse.
- `loops`  out  8  count of completed YELLOW→RED transitions; wraps at 256.

## Operation
- Stage 1 registers the lamp pins into `{r,y,g}_q`.
- Pattern decode of `{r,y,g}_q`:
  - 000 = OFF
  - 100 = RED
  - 110 = RED_YELLOW
  - 001 = GREEN
  - 010 = YELLOW
  - any other pattern = BAD
- Stage 2 is the phase FSM, holding `phase` and `dwell`. Each cycle it compares the decoded pattern (`dec`) with `phase`:
  - `dec == phase`: `dwell` increments, saturating.
  - `dec != phase`: `phase <= dec` and `dwell <= 1`. The transition is then checked.
- Legal transitions: OFF→RED, RED→RED_YELLOW, RED_YELLOW→GREEN, GREEN→YELLOW, YELLOW→RED, any phase→OFF, BAD→OFF.
- Every other change pulses `err_seq`. This includes entering BAD and leaving BAD to any phase other than OFF.
- Timing check:
  - Applies on a legal transition out of RED, RED_YELLOW, GREEN or YELLOW into a non-OFF phase.
  - Compares the old `dwell` with that phase's `*_CYCLES`; a mismatch pulses `err_time`.
  - Transitions into OFF (controller disabled) are never timing-checked; truncated phases are legal.
  - Transitions out of OFF or BAD are never timing-checked.
- On an illegal transition only `err_seq` pulses; `err_time` stays 0 that cycle.
- `loops` increments on every YELLOW→RED transition, whether or not its timing was correct.
- `fault`:
  - Set when `err_seq | err_time`.
  - Otherwise cleared when `fault_clr` is high.
  - Set wins over a simultaneous `fault_clr`.

## Timing
- Reset (asynchronous): lamp registers=000, `phase`=0001, `dwell`=0, `err_seq`=0, `err_time`=0, `fault`=0, `loops`=0.
- Latency: a lamp change sampled at edge k appears in the lamp registers at k. `phase`, `dwell`=1, error pulses and the `loops` update all appear at edge k+1, i.e. 2 cycles after the input change.
- `err_seq` and `err_time` are high for exactly one cycle per offending transition.
- A lamp pattern held 1 cycle is a full phase with dwell 1. No glitch filtering.
- `dwell` saturates at 2^DW−1 and does not wrap. A saturated dwell therefore mismatches any `*_CYCLES` value below 2^DW−1.
- Dwell matches the controller's convention: a phase whose internal timer reaches N lasts N+1 cycles. The defaults encode this.
- Reset asserted mid-phase aborts immediately. After release, the first non-OFF pattern is treated as a transition out of OFF: no timing check, and only RED is legal.

## Configuration
- `SEMAPHORE_MON_TIMING_EN` defined: dwell timing checks are present as described above.
- Not defined:
  - `err_time` is tied to 0 and never contributes to `fault`.
  - `dwell` still counts.
  - Only sequence legality is checked.

## Test plan
- Legal sequence OFF(5) → RED(51) → RY(11) → GREEN(31) → YELLOW(11) → RED: no error pulses, `fault`=0, `loops`=1, `phase` steps 0001→0010→0011→0100→0101→0010.
- RED held 50 cycles, then RED+YELLOW: one-cycle `err_time` at edge k+1, `fault`=1, `phase`=0011, `dwell`=1. With the macro undefined: no error.
- GREEN for 31 cycles, then RED: `err_seq` pulses, `err_time` stays 0, `phase`=0010.
- Lamps 101 → `phase`=1111 with `err_seq`; then 000 → OFF with no error; then 001 → `err_seq`.
- GREEN for 12 cycles, then 000 (disable): no error. Pulse `fault_clr` after a prior fault: `fault`=0. An error coinciding with `fault_clr`: `fault` stays 1.
- `rst_n` low mid-RED (dwell 20): outputs reset asynchronously, `loops`=0. After release, lamps 110: `err_seq`.
